// File: rtl/tx.sv
// Serial link transmitter: one-entry flit buffer feeding a framed bit-serial
// line (start bit, data LSB-first, even parity), gated by downstream busy.
`ifndef SIZE
`define SIZE 8
`endif

module tx #(
    parameter int SIZE = `SIZE
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req,
    output logic            busy,
    input  logic            busy_in,
    input  logic [SIZE-1:0] data,
    output logic            serial_out,
    output logic            active
);

    localparam int               CNT_W    = $clog2(SIZE + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SIZE);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        GAP    = 3'd4
    } state_t;

    state_t           state;
    logic [SIZE-1:0]  hold;
    logic             hold_valid;
    logic [SIZE-1:0]  sh;
    logic [CNT_W-1:0] cnt;
    logic             par;

    // Even parity: the transmitted bit makes the total count of ones even.
    function automatic logic even_parity(input logic [SIZE-1:0] v);
        return ^v;
    endfunction

    // The buffer flag is itself a register, so busy is registered.
    assign busy = hold_valid;

    // Holding register, frame sequencer and registered line outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            hold       <= '0;
            hold_valid <= 1'b0;
            sh         <= '0;
            cnt        <= '0;
            par        <= 1'b0;
            serial_out <= 1'b0;
            active     <= 1'b0;
        end else begin
            // Accept only into an empty buffer; a launch needs a full one,
            // so the two never act on hold_valid in the same cycle.
            if (req && !hold_valid) begin
                hold       <= data;
                hold_valid <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (hold_valid && !busy_in) begin
                        sh         <= hold;
                        hold_valid <= 1'b0;
                        par        <= even_parity(hold);
                        serial_out <= 1'b1;
                        active     <= 1'b1;
                        state      <= START;
                    end else begin
                        serial_out <= 1'b0;
                        active     <= 1'b0;
                    end
                end
                START: begin
                    serial_out <= sh[0];
                    sh         <= sh >> 1;
                    cnt        <= CNT_W'(1);
                    state      <= DATA;
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        serial_out <= par;
                        state      <= PARITY;
                    end else begin
                        serial_out <= sh[0];
                        sh         <= sh >> 1;
                        cnt        <= cnt + 1'b1;
                    end
                end
                PARITY: begin
                    serial_out <= 1'b0;
                    active     <= 1'b0;
                    state      <= GAP;
                end
                GAP: begin
                    // Guarantees at least one idle bit before the next start.
                    state <= IDLE;
                end
                default: begin
                    serial_out <= 1'b0;
                    active     <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx.sv
// Testbench for tx: directed scenarios plus randomized traffic checked against
// a timeline model of the serial line built from the frame rules.
module tb_tx;

    localparam int W    = 8;
    localparam int NCYC = 4096;

    logic         clk     = 1'b0;
    logic         reset   = 1'b1;
    logic         req     = 1'b0;
    logic         busy_in = 1'b0;
    logic [W-1:0] data    = '0;
    logic         busy;
    logic         serial_out;
    logic         active;

    tx #(.SIZE(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .busy      (busy),
        .busy_in   (busy_in),
        .data      (data),
        .serial_out(serial_out),
        .active    (active)
    );

    always #5 clk = ~clk;

    int cyc     = 0;
    int n_pass  = 0;
    int n_total = 0;

    // Expected line value and active flag after each clock edge index.
    logic         exp_ser [NCYC];
    logic         exp_act [NCYC];
    logic         m_hold_v;
    logic [W-1:0] m_hold;
    int           m_idle_from;

    task automatic clear_from(input int e);
        for (int i = e; i < NCYC; i++) begin
            exp_ser[i] = 1'b0;
            exp_act[i] = 1'b0;
        end
    endtask

    // Reference: a launch puts W+2 bits on the line starting at the launch
    // edge, and the next launch is possible no earlier than W+4 edges later.
    task automatic model_edge(input int e, input logic r, input logic [W-1:0] d, input logic bi);
        logic launch;
        logic accept;
        if (reset) begin
            clear_from(e);
            m_hold_v    = 1'b0;
            m_idle_from = 0;
        end else begin
            launch = m_hold_v && !bi && (e >= m_idle_from);
            accept = r && !m_hold_v;
            if (launch) begin
                for (int k = 0; k < W + 2; k++) begin
                    if (e + k < NCYC) begin
                        exp_act[e + k] = 1'b1;
                        if (k == 0)       exp_ser[e + k] = 1'b1;
                        else if (k <= W)  exp_ser[e + k] = m_hold[k - 1];
                        else              exp_ser[e + k] = ^m_hold;
                    end
                end
                m_hold_v    = 1'b0;
                m_idle_from = e + W + 4;
            end
            if (accept) begin
                m_hold_v = 1'b1;
                m_hold   = d;
            end
        end
    endtask

    task automatic tick(input logic r, input logic [W-1:0] d, input logic bi);
        req     = r;
        data    = d;
        busy_in = bi;
        @(posedge clk);
        cyc++;
        model_edge(cyc, r, d, bi);
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_total++;
        if (serial_out !== 1'b0 || active !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_async ser=%b act=%b busy=%b required 0/0/0", serial_out, active, busy);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            tick(1'($urandom_range(0, 1)), W'($urandom), 1'b0);
            n_total++;
            if (serial_out !== 1'b0 || active !== 1'b0 || busy !== 1'b0)
                $display("FAIL reset_hold cyc=%0d ser=%b act=%b busy=%b required 0/0/0", cyc, serial_out, active, busy);
            else n_pass++;
        end
        reset = 1'b0;
        tick(1'b0, '0, 1'b0);
        n_total++;
        if (serial_out !== 1'b0 || active !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_release ser=%b act=%b busy=%b required 0/0/0", serial_out, active, busy);
        else n_pass++;
    endtask

    task automatic test_single();
        logic [0:9] seq;
        seq = 10'b1101001010;
        tick(1'b1, 8'hA5, 1'b0);
        n_total++;
        if (busy !== 1'b1 || active !== 1'b0)
            $display("FAIL single_accept busy=%b act=%b required 1/0", busy, active);
        else n_pass++;
        for (int k = 0; k < 10; k++) begin
            tick(1'b0, '0, 1'b0);
            n_total++;
            if (serial_out !== seq[k] || active !== 1'b1)
                $display("FAIL single_bit k=%0d ser=%b act=%b required %b/1", k, serial_out, active, seq[k]);
            else n_pass++;
            if (k == 0) begin
                n_total++;
                if (busy !== 1'b0) $display("FAIL single_busy_fall busy=%b required 0", busy);
                else n_pass++;
            end
        end
        tick(1'b0, '0, 1'b0);
        n_total++;
        if (serial_out !== 1'b0 || active !== 1'b0)
            $display("FAIL single_end ser=%b act=%b required 0/0", serial_out, active);
        else n_pass++;
        tick(1'b0, '0, 1'b0);
        tick(1'b0, '0, 1'b0);
    endtask

    task automatic test_parity();
        logic [0:9] f07;
        logic [0:9] f00;
        f07 = 10'b1111000001;
        f00 = 10'b1000000000;
        for (int v = 0; v < 2; v++) begin
            tick(1'b1, (v == 0) ? 8'h07 : 8'h00, 1'b0);
            for (int k = 0; k < 10; k++) begin
                tick(1'b0, '0, 1'b0);
                n_total++;
                if (serial_out !== ((v == 0) ? f07[k] : f00[k]))
                    $display("FAIL parity_frame v=%0d k=%0d ser=%b required %b", v, k, serial_out,
                             (v == 0) ? f07[k] : f00[k]);
                else n_pass++;
            end
            tick(1'b0, '0, 1'b0);
            tick(1'b0, '0, 1'b0);
        end
    endtask

    task automatic test_busy_in();
        tick(1'b1, W'($urandom), 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, '0, 1'b1);
            n_total++;
            if (busy !== 1'b1 || active !== 1'b0 || serial_out !== 1'b0)
                $display("FAIL busyin_wait i=%0d busy=%b act=%b ser=%b required 1/0/0", i, busy, active, serial_out);
            else n_pass++;
        end
        tick(1'b0, '0, 1'b0);
        n_total++;
        if (serial_out !== 1'b1 || active !== 1'b1 || busy !== 1'b0)
            $display("FAIL busyin_start ser=%b act=%b busy=%b required 1/1/0", serial_out, active, busy);
        else n_pass++;
        for (int i = 0; i < W + 3; i++) begin
            tick(1'b0, '0, 1'($urandom_range(0, 1)));
            n_total++;
            if (serial_out !== exp_ser[cyc] || active !== exp_act[cyc])
                $display("FAIL busyin_frame cyc=%0d ser=%b act=%b required %b/%b", cyc, serial_out, active,
                         exp_ser[cyc], exp_act[cyc]);
            else n_pass++;
        end
        tick(1'b0, '0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int   s1;
        int   s2;
        logic prev_act;
        s2 = -1;
        tick(1'b1, 8'h5A, 1'b0);
        tick(1'b0, '0, 1'b0);
        s1 = cyc;
        n_total++;
        if (serial_out !== 1'b1 || active !== 1'b1)
            $display("FAIL b2b_first_start ser=%b act=%b required 1/1", serial_out, active);
        else n_pass++;
        tick(1'b1, 8'h3C, 1'b0);
        n_total++;
        if (busy !== 1'b1) $display("FAIL b2b_second_accept busy=%b required 1", busy);
        else n_pass++;
        tick(1'b1, 8'hFF, 1'b0);
        prev_act = active;
        for (int i = 0; i < 40 && s2 < 0; i++) begin
            tick(1'b0, '0, 1'b0);
            n_total++;
            if (serial_out !== exp_ser[cyc] || active !== exp_act[cyc] || busy !== m_hold_v)
                $display("FAIL b2b_line cyc=%0d ser=%b act=%b busy=%b required %b/%b/%b", cyc, serial_out,
                         active, busy, exp_ser[cyc], exp_act[cyc], m_hold_v);
            else n_pass++;
            if (active && !prev_act) s2 = cyc;
            prev_act = active;
        end
        n_total++;
        if (s2 - s1 !== 12) $display("FAIL b2b_spacing got=%0d required 12", s2 - s1);
        else n_pass++;
        for (int i = 0; i < W + 4; i++) begin
            tick(1'b0, '0, 1'b0);
            n_total++;
            if (serial_out !== exp_ser[cyc] || active !== exp_act[cyc])
                $display("FAIL b2b_tail cyc=%0d ser=%b act=%b required %b/%b", cyc, serial_out, active,
                         exp_ser[cyc], exp_act[cyc]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        tick(1'b1, W'($urandom), 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b0, '0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        clear_from(cyc);
        m_hold_v    = 1'b0;
        m_idle_from = 0;
        n_total++;
        if (serial_out !== 1'b0 || active !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_mid ser=%b act=%b busy=%b required 0/0/0", serial_out, active, busy);
        else n_pass++;
        tick(1'b0, '0, 1'b0);
        tick(1'b0, '0, 1'b0);
        reset = 1'b0;
        tick(1'b1, W'($urandom), 1'b0);
        for (int i = 0; i < W + 5; i++) begin
            tick(1'b0, '0, 1'b0);
            n_total++;
            if (serial_out !== exp_ser[cyc] || active !== exp_act[cyc] || busy !== m_hold_v)
                $display("FAIL reset_mid_after cyc=%0d ser=%b act=%b busy=%b required %b/%b/%b", cyc,
                         serial_out, active, busy, exp_ser[cyc], exp_act[cyc], m_hold_v);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            tick(($urandom_range(0, 2) == 0), W'($urandom), ($urandom_range(0, 3) == 0));
            n_total++;
            if (serial_out !== exp_ser[cyc] || active !== exp_act[cyc] || busy !== m_hold_v)
                $display("FAIL random cyc=%0d ser=%b act=%b busy=%b required %b/%b/%b", cyc, serial_out,
                         active, busy, exp_ser[cyc], exp_act[cyc], m_hold_v);
            else n_pass++;
        end
    endtask

    initial begin
        clear_from(0);
        m_hold_v    = 1'b0;
        m_hold      = '0;
        m_idle_from = 0;
        test_reset();
        test_single();
        test_parity();
        test_busy_in();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
